uibi_ram_slave: RTL and testbench

Single-port RAM responder on the UIBI bus, at the opposite end of the interface from the CPU's memory unit. Decodes the bus number, accepts one transaction at a time, inserts a configurable number of wait states and returns `bus_ready` with byte/half/word read data extended per `bus_mode`. Serves as the main instruction/data memory target behind the bus interconnect.

---
 rtl/uibi_ram_slave.sv | 160 ++++++++++++++++
 tb/tb_uibi_ram_slave.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uibi_ram_slave.sv
// uibi_ram_slave: single-port RAM responder on the UIBI bus with wait states.
// Optional: define UIBI_RAM_ERR_EN for misalignment detection and sticky err.
module uibi_ram_slave #(
  parameter int unsigned SLAVE_NUM = 0,
  parameter int unsigned NUM_W     = 4,
  parameter int unsigned AW        = 12,
  parameter int unsigned LATENCY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_req,
  input  logic [NUM_W-1:0] bus_num,
  input  logic             bus_wen,
  input  logic [2:0]       bus_mode,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_dat_w,
  output logic [31:0]      bus_dat_r,
  output logic             bus_ready,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        wen;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] dat;
  } req_t;

  localparam logic [NUM_W-1:0] SEL = NUM_W'(SLAVE_NUM);
  localparam logic [3:0]       LAT = 4'(LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;

  logic        is_b, is_h, sx, mis;
  logic [1:0]  shift;
  logic [3:0]  be;
  logic [31:0] wdata, rword, rdata;
  logic [AW-1:0] idx;

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (bus_req && bus_num == SEL) begin
          req_d.wen  = bus_wen;
          req_d.mode = bus_mode;
          req_d.addr = bus_addr;
          req_d.dat  = bus_dat_w;
          cnt_d      = LAT;
          state_d    = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign is_b = (req_q.mode[1:0] == 2'b00);
  assign is_h = (req_q.mode[1:0] == 2'b01);
  assign sx   = ~req_q.mode[2];
  assign idx  = req_q.addr[AW+1:2];

  always_comb begin
    shift = '0;
    be    = '0;
    unique case (1'b1)
      is_b: begin
        shift = req_q.addr[1:0];
        be    = 4'b0001 << shift;
      end
      is_h: begin
        shift = {req_q.addr[1], 1'b0};
        be    = 4'b0011 << shift;
      end
      default: begin
        shift = '0;
        be    = 4'b1111;
      end
    endcase
  end

  assign wdata = req_q.dat << {shift, 3'b000};
  assign rword = mem[idx] >> {shift, 3'b000};

  always_comb begin
    rdata = rword;
    unique case (1'b1)
      is_b:    rdata = {{24{sx & rword[7]}}, rword[7:0]};
      is_h:    rdata = {{16{sx & rword[15]}}, rword[15:0]};
      default: rdata = rword;
    endcase
  end

`ifdef UIBI_RAM_ERR_EN
  logic err_q;

  assign mis = (is_h & req_q.addr[0])
             | (~is_b & ~is_h & (req_q.addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (bus_ready && mis) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign mis = 1'b0;
  assign err = 1'b0;
`endif

  assign bus_ready = (state_q == RESP);
  assign bus_dat_r = (bus_ready && !req_q.wen && !mis) ? rdata : '0;

  // Array is deliberately left out of reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (bus_ready && req_q.wen && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic unused_hi;
  assign unused_hi = ^req_q.addr[31:AW+2];

endmodule

// File: tb/tb_uibi_ram_slave.sv
// tb_uibi_ram_slave: table vectors, corner sequences and random traffic
// checked against a byte-array model of the RAM responder.
module tb_uibi_ram_slave;

  localparam int SN  = 3;
  localparam int NW  = 4;
  localparam int AWP = 4;
  localparam int LAT = 1;
  localparam int MB  = 4 * (1 << AWP);

`ifdef UIBI_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bus_req = 1'b0;
  logic [NW-1:0] bus_num = '0;
  logic          bus_wen = 1'b0;
  logic [2:0]    bus_mode = '0;
  logic [31:0]   bus_addr = '0;
  logic [31:0]   bus_dat_w = '0;
  logic [31:0]   bus_dat_r;
  logic          bus_ready;
  logic          err;

  int n_chk = 0;
  int n_pass = 0;
  bit mis_seen = 1'b0;
  logic [7:0] mem_m [MB];

  always #5 clk = ~clk;

  uibi_ram_slave #(
    .SLAVE_NUM(SN), .NUM_W(NW), .AW(AWP), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_num(bus_num),
    .bus_wen(bus_wen), .bus_mode(bus_mode), .bus_addr(bus_addr),
    .bus_dat_w(bus_dat_w), .bus_dat_r(bus_dat_r),
    .bus_ready(bus_ready), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic int nbytes(input logic [2:0] m);
    if (m[1:0] == 2'b00) return 1;
    if (m[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [2:0] m);
    if (!ERR_EN) return 1'b0;
    if (m[1:0] == 2'b01) return a[0];
    if (m[1]) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic int base_of(input logic [31:0] a, input logic [2:0] m);
    int n, off;
    n = nbytes(m);
    off = int'(a & 32'(MB - 1));
    return (off / n) * n;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a,
                                        input logic [2:0] m);
    logic [31:0] v;
    int n, b;
    if (misal(a, m)) return 32'h0;
    n = nbytes(m);
    b = base_of(a, m);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[b+i]) << (8*i));
    if (n == 1 && !m[2] && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !m[2] && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [2:0] m,
                        input logic [31:0] d);
    int n, b;
    if (misal(a, m)) return;
    n = nbytes(m);
    b = base_of(a, m);
    for (int i = 0; i < n; i++) mem_m[b+i] = d[8*i +: 8];
  endtask

  // Called at a negedge with the slave idle; returns at a negedge, idle.
  task automatic txn(input logic w, input logic [2:0] m,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    int lat;
    bit dirty;
    lat = -1;
    dirty = 1'b0;
    r = 32'h0;
    bus_num = NW'(SN);
    bus_wen = w;
    bus_mode = m;
    bus_addr = a;
    bus_dat_w = d;
    bus_req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus_ready) begin
        lat = k;
        r = bus_dat_r;
        break;
      end
      if (bus_dat_r != 32'h0) dirty = 1'b1;
      if (k == 1) begin
        bus_addr = $urandom;
        bus_dat_w = $urandom;
        bus_wen = ~bus_wen;
        bus_mode = 3'($urandom);
      end
    end
    bus_req = 1'b0;
    chk("latency", 32'(lat), 32'(LAT + 1));
    chk("dat_r_idle", {31'b0, dirty}, 32'h0);
    @(negedge clk);
    chk("ready_pulse", {31'b0, bus_ready}, 32'h0);
  endtask

  task automatic run(input string nm, input logic w, input logic [2:0] m,
                     input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r, e;
    e = w ? 32'h0 : mread(a, m);
    txn(w, m, a, d, r);
    chk(nm, r, e);
    if (w) mwrite(a, m, d);
    if (misal(a, m)) mis_seen = 1'b1;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  m;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    logic [31:0] r, exp;
    int p[$];
    int rc;

    tbl[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0};
    tbl[3]  = '{1'b1, 3'b000, 32'h13, 32'h1234565A, 32'h0};
    tbl[4]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'h0000005A};
    tbl[5]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h5A223344};
    tbl[6]  = '{1'b1, 3'b001, 32'h14, 32'hABCD80C3, 32'h0};
    tbl[7]  = '{1'b0, 3'b001, 32'h14, 32'h0,        32'hFFFF80C3};
    tbl[8]  = '{1'b0, 3'b101, 32'h14, 32'h0,        32'h000080C3};
    tbl[9]  = '{1'b0, 3'b100, 32'h15, 32'h0,        32'h00000080};
    tbl[10] = '{1'b0, 3'b000, 32'h15, 32'h0,        32'hFFFFFF80};
    tbl[11] = '{1'b1, 3'b010, 32'h40, 32'h00000001, 32'h0};
    tbl[12] = '{1'b0, 3'b010, 32'h00, 32'h0,        32'h00000001};
    tbl[13] = '{1'b1, 3'b000, 32'h02, 32'h000000AB, 32'h0};
    tbl[14] = '{1'b0, 3'b010, 32'h00, 32'h0,        32'h00AB0001};
    tbl[15] = '{1'b0, 3'b101, 32'h02, 32'h0,        32'h000000AB};
    tbl[16] = '{1'b0, 3'b000, 32'h02, 32'h0,        32'hFFFFFFAB};
    tbl[17] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h5A223344};

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus_ready}, 32'h0);
    chk("rst_dat_r", bus_dat_r, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < MB / 4; i++) begin
      logic [31:0] d;
      d = $urandom;
      txn(1'b1, 3'b010, 32'(4 * i), d, r);
      mwrite(32'(4 * i), 3'b010, d);
    end

    for (int i = 0; i < NV; i++) begin
      txn(tbl[i].w, tbl[i].m, tbl[i].a, tbl[i].d, r);
      chk($sformatf("tbl%0d", i), r, tbl[i].e);
      if (tbl[i].w) mwrite(tbl[i].a, tbl[i].m, tbl[i].d);
    end

    run("mis_wr", 1'b1, 3'b010, 32'h22, 32'hCAFEF00D);
    chk("mis_err", {31'b0, err}, {31'b0, ERR_EN});
    run("mis_rd_word", 1'b0, 3'b010, 32'h20, 32'h0);
    run("mis_rd_half", 1'b0, 3'b101, 32'h21, 32'h0);

    bus_num = NW'(SN + 1);
    bus_wen = 1'b1;
    bus_mode = 3'b010;
    bus_addr = 32'h10;
    bus_dat_w = 32'hFFFFFFFF;
    bus_req = 1'b1;
    rc = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_ready) rc++;
    end
    bus_req = 1'b0;
    chk("wrong_num_ready", 32'(rc), 32'h0);
    @(negedge clk);
    run("wrong_num_mem", 1'b0, 3'b010, 32'h10, 32'h0);

    exp = mread(32'h10, 3'b010);
    bus_num = NW'(SN);
    bus_wen = 1'b0;
    bus_mode = 3'b010;
    bus_addr = 32'h10;
    bus_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus_ready) begin
        p.push_back(k);
        chk("tp_data", bus_dat_r, exp);
      end
    end
    bus_req = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("tp_first", p.size() > 0 ? 32'(p[0]) : 32'hFFFF_FFFF, 32'(LAT + 1));
    chk("tp_gap", p.size() > 1 ? 32'(p[1] - p[0]) : 32'hFFFF_FFFF,
        32'(LAT + 2));

    bus_num = NW'(SN);
    bus_wen = 1'b1;
    bus_mode = 3'b010;
    bus_addr = 32'h18;
    bus_dat_w = 32'h12345678;
    bus_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_req = 1'b0;
    #1;
    chk("rst_mid_ready", {31'b0, bus_ready}, 32'h0);
    @(negedge clk);
    chk("rst_mid_ready2", {31'b0, bus_ready}, 32'h0);
    rst = 1'b1;
    mis_seen = 1'b0;
    @(negedge clk);
    chk("rst_err_clr", {31'b0, err}, 32'h0);
    run("rst_mid_mem", 1'b0, 3'b010, 32'h18, 32'h0);

    for (int i = 0; i < 150; i++) begin
      run("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          $urandom, $urandom);
    end
    chk("err_final", {31'b0, err}, {31'b0, mis_seen});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
